// File: rtl/fwrisc_mem_arb_pkg.sv
// fwrisc_mem_arb_pkg
// Shared types and constants for the fwrisc memory arbiter.
// - arb_state_e : arbiter FSM states (idle, fetch port granted, data port granted)
// - PRIO_FIXED / PRIO_RR : values for the PRIO_MODE parameter
// - PORT_I / PORT_D : encoding of a requester port (last_gnt, err_port)
package fwrisc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/fwrisc_mem_arb_wdog.sv
// fwrisc_mem_arb_wdog
// Watchdog counter for a granted memory access. Counts enabled cycles and
// flags expiry when the count reaches TIMEOUT_CYCLES-1, i.e. during the
// TIMEOUT_CYCLES-th enabled cycle. The counter saturates instead of wrapping.
// TIMEOUT_CYCLES = 0 disables expiry altogether.
// Ports:
// - clock  : clock, state on posedge
// - reset  : synchronous active-high reset
// - clear  : synchronous clear (has priority over enable)
// - enable : count this cycle
// - expire : count has reached the limit (combinational from the count)
module fwrisc_mem_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Watchdog count: cleared on request, saturating increment while enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && (count_r == LIMIT);

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
// Shares one single-ported memory bus between the fwrisc fetch port (I,
// read-only) and data port (D, load/store). One port is granted at a time;
// the grant is held until the memory completes (m_valid && m_ready), the
// requester drops its valid, or the watchdog expires. Completion and timeout
// return the FSM to IDLE, giving one bubble cycle between grants.
// Parameters:
// - PRIO_MODE      : 0 = fixed priority (D wins ties), 1 = round-robin on ties
// - TIMEOUT_CYCLES : granted cycles without m_ready before timeout, 0 = off
// Ports:
// - clock, reset                      : clock, synchronous active-high reset
// - i_addr/i_valid -> i_rdata/i_ready : fetch request / response
// - d_addr/d_wdata/d_strb/d_write/d_valid -> d_rdata/d_ready : data request / response
// - m_addr/m_wdata/m_strb/m_write/m_valid <- m_rdata/m_ready : memory bus
// - bus_err  : one-cycle pulse on watchdog timeout
// - err_port : port of the most recent timeout (0 = I, 1 = D)
module fwrisc_mem_arbiter #(
    parameter int PRIO_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strb,
    input  logic        d_write,
    input  logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_strb,
    output logic        m_write,
    output logic        m_valid,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        bus_err,
    output logic        err_port
);
    import fwrisc_mem_arb_pkg::*;

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       last_gnt_r;
    logic       err_port_r;
    logic       xfer_s;
    logic       tmo_s;
    logic       gnt_port_s;
    logic       wd_clear_s;
    logic       wd_enable_s;
    logic       wd_expire_s;

    fwrisc_mem_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear_s),
        .enable (wd_enable_s),
        .expire (wd_expire_s)
    );

    // Next-state decode, bus mux and response routing for the granted port.
    always_comb begin
        state_nxt_s = state_r;
        i_rdata     = 32'h0000_0000;
        i_ready     = 1'b0;
        d_rdata     = 32'h0000_0000;
        d_ready     = 1'b0;
        m_addr      = 32'h0000_0000;
        m_wdata     = 32'h0000_0000;
        m_strb      = 4'h0;
        m_write     = 1'b0;
        m_valid     = 1'b0;
        xfer_s      = 1'b0;
        tmo_s       = 1'b0;
        gnt_port_s  = PORT_I;
        wd_clear_s  = 1'b1;
        wd_enable_s = 1'b0;

        if (reset) begin
            // Everything stays quiet while reset is held.
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid && d_valid) begin
                        // Round-robin hands a tie to the port not served last.
                        if ((PRIO_MODE == PRIO_RR) && (last_gnt_r == PORT_D)) begin
                            state_nxt_s = GNT_I;
                        end else begin
                            state_nxt_s = GNT_D;
                        end
                    end else if (d_valid) begin
                        state_nxt_s = GNT_D;
                    end else if (i_valid) begin
                        state_nxt_s = GNT_I;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                GNT_I: begin
                    gnt_port_s  = PORT_I;
                    m_addr      = i_addr;
                    m_strb      = 4'hf;
                    m_valid     = i_valid;
                    xfer_s      = i_valid && m_ready;
                    // m_ready in the expiry cycle still wins as a normal completion.
                    tmo_s       = i_valid && !m_ready && wd_expire_s;
                    i_ready     = xfer_s || tmo_s;
                    i_rdata     = xfer_s ? m_rdata : 32'h0000_0000;
                    wd_enable_s = i_valid;
                    wd_clear_s  = !i_valid || xfer_s || tmo_s;
                    // A dropped valid abandons the grant without a response.
                    if (!i_valid || xfer_s || tmo_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = GNT_I;
                    end
                end
                GNT_D: begin
                    gnt_port_s  = PORT_D;
                    m_addr      = d_addr;
                    m_wdata     = d_wdata;
                    m_strb      = d_strb;
                    m_write     = d_write;
                    m_valid     = d_valid;
                    xfer_s      = d_valid && m_ready;
                    tmo_s       = d_valid && !m_ready && wd_expire_s;
                    d_ready     = xfer_s || tmo_s;
                    d_rdata     = xfer_s ? m_rdata : 32'h0000_0000;
                    wd_enable_s = d_valid;
                    wd_clear_s  = !d_valid || xfer_s || tmo_s;
                    if (!d_valid || xfer_s || tmo_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = GNT_D;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end

        bus_err  = tmo_s;
        err_port = err_port_r & ~reset;
    end

    // FSM state, last-granted port and timeout port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            last_gnt_r <= PORT_I;
            err_port_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (xfer_s || tmo_s) begin
                last_gnt_r <= gnt_port_s;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            if (tmo_s) begin
                err_port_r <= gnt_port_s;
            end else begin
                err_port_r <= err_port_r;
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb_fwrisc_mem_arbiter
// Self-checking bench for fwrisc_mem_arbiter. Two instances share the clock
// and reset: dut_a (fixed priority, TIMEOUT_CYCLES = 4) and dut_b
// (round-robin, TIMEOUT_CYCLES = 4). Expected responses are queued per
// instance when a request is driven and popped by a monitor on each ready.
module tb_fwrisc_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;
    logic [3:0]  a_d_strb, a_m_strb;
    logic        a_i_valid, a_i_ready, a_d_write, a_d_valid, a_d_ready;
    logic        a_m_write, a_m_valid, a_m_ready, a_bus_err, a_err_port;

    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;
    logic [3:0]  b_d_strb, b_m_strb;
    logic        b_i_valid, b_i_ready, b_d_write, b_d_valid, b_d_ready;
    logic        b_m_write, b_m_valid, b_m_ready, b_bus_err, b_err_port;

    fwrisc_mem_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(4)) dut_a (
        .clock(clk), .reset(reset),
        .i_addr(a_i_addr), .i_valid(a_i_valid), .i_rdata(a_i_rdata), .i_ready(a_i_ready),
        .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_strb(a_d_strb), .d_write(a_d_write),
        .d_valid(a_d_valid), .d_rdata(a_d_rdata), .d_ready(a_d_ready),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_strb(a_m_strb), .m_write(a_m_write),
        .m_valid(a_m_valid), .m_rdata(a_m_rdata), .m_ready(a_m_ready),
        .bus_err(a_bus_err), .err_port(a_err_port)
    );

    fwrisc_mem_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(4)) dut_b (
        .clock(clk), .reset(reset),
        .i_addr(b_i_addr), .i_valid(b_i_valid), .i_rdata(b_i_rdata), .i_ready(b_i_ready),
        .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_strb(b_d_strb), .d_write(b_d_write),
        .d_valid(b_d_valid), .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_strb(b_m_strb), .m_write(b_m_write),
        .m_valid(b_m_valid), .m_rdata(b_m_rdata), .m_ready(b_m_ready),
        .bus_err(b_bus_err), .err_port(b_err_port)
    );

    // Expected response: which port answers, its read data and bus_err.
    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for dut_a: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (a_i_ready || a_d_ready)) begin
            check("a_one_hot_ready", {31'd0, a_i_ready & a_d_ready}, 32'd0);
            if (q_a.size() == 0) begin
                check("a_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_port", {31'd0, a_d_ready}, {31'd0, e.port});
                check("a_rdata", a_d_ready ? a_d_rdata : a_i_rdata, e.rdata);
                check("a_bus_err", {31'd0, a_bus_err}, {31'd0, e.err});
            end
        end
    end

    // Scoreboard for dut_b: grant order shows up as the order of ready pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (b_i_ready || b_d_ready)) begin
            check("b_one_hot_ready", {31'd0, b_i_ready & b_d_ready}, 32'd0);
            if (q_b.size() == 0) begin
                check("b_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_port", {31'd0, b_d_ready}, {31'd0, e.port});
                check("b_rdata", b_d_ready ? b_d_rdata : b_i_rdata, e.rdata);
                check("b_bus_err", {31'd0, b_bus_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int seen;
        int cyc;

        reset     = 1'b1;
        a_i_addr  = 32'h0; a_i_valid = 1'b0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
        a_d_strb  = 4'h0;  a_d_write = 1'b0; a_d_valid = 1'b0; a_m_rdata = 32'h0; a_m_ready = 1'b0;
        b_i_addr  = 32'h0; b_i_valid = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0;
        b_d_strb  = 4'h0;  b_d_write = 1'b0; b_d_valid = 1'b0; b_m_rdata = 32'h0; b_m_ready = 1'b0;

        // Reset: outputs stay low even with a request pending.
        tick();
        a_i_valid = 1'b1;
        a_m_ready = 1'b1;
        @(negedge clk);
        check("rst_m_valid", {31'd0, a_m_valid}, 32'd0);
        check("rst_i_ready", {31'd0, a_i_ready}, 32'd0);
        check("rst_err_port", {31'd0, a_err_port}, 32'd0);
        check("rst_bus_err", {31'd0, a_bus_err}, 32'd0);
        tick();
        a_i_valid = 1'b0;
        a_m_ready = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check("idle_m_valid", {31'd0, a_m_valid}, 32'd0);

        // Single fetch, memory answers in the 2nd granted cycle.
        tick();
        a_i_addr  = 32'h0000_0100;
        a_i_valid = 1'b1;
        q_a.push_back('{1'b0, 32'h0000_0013, 1'b0});
        @(negedge clk);
        check("fetch_lat_idle", {31'd0, a_m_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("fetch_m_valid", {31'd0, a_m_valid}, 32'd1);
        check("fetch_m_addr", a_m_addr, 32'h0000_0100);
        check("fetch_m_strb", {28'd0, a_m_strb}, 32'hf);
        check("fetch_m_write", {31'd0, a_m_write}, 32'd0);
        check("fetch_no_ready", {31'd0, a_i_ready}, 32'd0);
        tick();
        a_m_ready = 1'b1;
        a_m_rdata = 32'h0000_0013;
        @(negedge clk);
        check("fetch_i_ready", {31'd0, a_i_ready}, 32'd1);
        check("fetch_d_ready", {31'd0, a_d_ready}, 32'd0);
        tick();
        a_i_valid = 1'b0;
        a_m_ready = 1'b0;
        @(negedge clk);
        check("fetch_done_m_valid", {31'd0, a_m_valid}, 32'd0);

        // Tie under fixed priority: store on D first, then the fetch after a bubble.
        tick();
        a_i_addr  = 32'h0000_0104; a_i_valid = 1'b1;
        a_d_addr  = 32'h0000_0200; a_d_wdata = 32'h1234_5678; a_d_strb = 4'h3;
        a_d_write = 1'b1;          a_d_valid = 1'b1;
        a_m_ready = 1'b1;          a_m_rdata = 32'h0000_0011;
        q_a.push_back('{1'b1, 32'h0000_0011, 1'b0});
        q_a.push_back('{1'b0, 32'h0000_0011, 1'b0});
        @(negedge clk);
        tick();
        @(negedge clk);
        check("tie_d_ready", {31'd0, a_d_ready}, 32'd1);
        check("tie_m_write", {31'd0, a_m_write}, 32'd1);
        check("tie_m_strb", {28'd0, a_m_strb}, 32'h3);
        check("tie_m_addr", a_m_addr, 32'h0000_0200);
        check("tie_m_wdata", a_m_wdata, 32'h1234_5678);
        tick();
        a_d_valid = 1'b0;
        a_d_write = 1'b0;
        @(negedge clk);
        check("tie_bubble", {31'd0, a_m_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("tie_i_ready", {31'd0, a_i_ready}, 32'd1);
        check("tie_i_m_addr", a_m_addr, 32'h0000_0104);
        tick();
        a_i_valid = 1'b0;
        a_m_ready = 1'b0;

        // Watchdog timeout on a load: 4 granted cycles without m_ready.
        a_d_addr  = 32'h0000_0300; a_d_valid = 1'b1; a_d_strb = 4'hf;
        a_m_rdata = 32'hDEAD_BEEF;
        q_a.push_back('{1'b1, 32'h0000_0000, 1'b1});
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            tick();
            @(negedge clk);
            check("tmo_m_valid", {31'd0, a_m_valid}, 32'd1);
            check("tmo_early_err", {31'd0, a_bus_err}, 32'd0);
        end
        tick();
        @(negedge clk);
        check("tmo_d_ready", {31'd0, a_d_ready}, 32'd1);
        check("tmo_bus_err", {31'd0, a_bus_err}, 32'd1);
        check("tmo_err_port_pre", {31'd0, a_err_port}, 32'd0);
        tick();
        a_d_valid = 1'b0;
        @(negedge clk);
        check("tmo_m_valid_after", {31'd0, a_m_valid}, 32'd0);
        check("tmo_err_port", {31'd0, a_err_port}, 32'd1);
        check("tmo_err_pulse", {31'd0, a_bus_err}, 32'd0);

        // Boundary: m_ready lands in exactly the 4th granted cycle.
        tick();
        a_d_addr  = 32'h0000_0304; a_d_valid = 1'b1;
        a_m_rdata = 32'h0000_BEEF;
        q_a.push_back('{1'b1, 32'h0000_BEEF, 1'b0});
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            tick();
            @(negedge clk);
            check("bnd_wait", {31'd0, a_d_ready}, 32'd0);
        end
        tick();
        a_m_ready = 1'b1;
        @(negedge clk);
        check("bnd_d_ready", {31'd0, a_d_ready}, 32'd1);
        check("bnd_bus_err", {31'd0, a_bus_err}, 32'd0);
        tick();
        a_d_valid = 1'b0;
        a_m_ready = 1'b0;
        @(negedge clk);
        check("bnd_err_port_hold", {31'd0, a_err_port}, 32'd1);

        // Reset in the 2nd GNT_I cycle drops the fetch; a fresh fetch then works.
        tick();
        a_i_addr  = 32'h0000_0400; a_i_valid = 1'b1;
        a_m_rdata = 32'h0000_0066;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rmid_m_valid_c1", {31'd0, a_m_valid}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rmid_m_valid", {31'd0, a_m_valid}, 32'd0);
        check("rmid_i_ready", {31'd0, a_i_ready}, 32'd0);
        tick();
        reset     = 1'b0;
        a_i_valid = 1'b0;
        @(negedge clk);
        check("rmid_idle", {31'd0, a_m_valid}, 32'd0);
        check("rmid_err_port", {31'd0, a_err_port}, 32'd0);
        tick();
        a_i_addr  = 32'h0000_0404; a_i_valid = 1'b1;
        a_m_ready = 1'b1;          a_m_rdata = 32'h0000_0077;
        q_a.push_back('{1'b0, 32'h0000_0077, 1'b0});
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rmid_fresh_ready", {31'd0, a_i_ready}, 32'd1);
        check("rmid_fresh_addr", a_m_addr, 32'h0000_0404);
        tick();
        a_i_valid = 1'b0;
        a_m_ready = 1'b0;

        // Round-robin ties: last_gnt starts at I, so D, I, D, I.
        b_i_addr  = 32'h0000_0500; b_i_valid = 1'b1;
        b_d_addr  = 32'h0000_0600; b_d_valid = 1'b1; b_d_strb = 4'hf;
        b_m_ready = 1'b1;          b_m_rdata = 32'h0000_0055;
        q_b.push_back('{1'b1, 32'h0000_0055, 1'b0});
        q_b.push_back('{1'b0, 32'h0000_0055, 1'b0});
        q_b.push_back('{1'b1, 32'h0000_0055, 1'b0});
        q_b.push_back('{1'b0, 32'h0000_0055, 1'b0});
        seen = 0;
        cyc  = 0;
        while ((seen < 4) && (cyc < 20)) begin
            @(negedge clk);
            if (b_i_ready || b_d_ready) begin
                seen++;
            end
            cyc++;
            if (seen < 4) begin
                tick();
            end
        end
        tick();
        b_i_valid = 1'b0;
        b_d_valid = 1'b0;
        b_m_ready = 1'b0;
        check("rr_grant_count", seen, 32'd4);

        tick();
        @(negedge clk);
        check("a_sb_empty", q_a.size(), 32'd0);
        check("b_sb_empty", q_b.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
